// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// The FSM state encoding and the POR majority vote live here.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERTED = 2'd0,
    STRETCH  = 2'd1,
    RELEASE  = 2'd2,
    RUN      = 2'd3
  } seq_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/reset_sync_2ff.sv
// Two-flop synchroniser for one POR status bit.
// Resets to 1 so that the domain stays in reset until the synced value is known.
module reset_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller: votes triplicated POR, stretches reset, then releases domains in order.
// Optional saturating POR disagreement counter when RESET_SEQ_MISMATCH_CNT_EN is defined.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_DOMAINS      = 3,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           por_status,
  input  logic                 sw_rst_req,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
`ifdef RESET_SEQ_MISMATCH_CNT_EN
  output logic [CNT_W-1:0]     mismatch_cnt,
`endif
  output logic                 por_mismatch
);

  localparam int unsigned MaxCyc =
      (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CW = $clog2(MaxCyc + 1);
  localparam int unsigned IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  logic [2:0]    por_sync;
  logic          por_v;
  logic          cause;
  logic          mismatch;
  seq_state_e    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  for (genvar i = 0; i < 3; i++) begin : g_sync
    reset_sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (por_status[i]),
      .q   (por_sync[i])
    );
  end

  assign por_v    = maj3(por_sync[0], por_sync[1], por_sync[2]);
  assign cause    = por_v | sw_rst_req;
  assign mismatch = (|por_sync) & ~(&por_sync);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ASSERTED;
      cnt        <= '0;
      idx        <= '0;
      domain_rst <= '1;
      ready      <= 1'b0;
    end else if (cause) begin
      // Any cause restarts the whole sequence; partial releases are discarded.
      state      <= ASSERTED;
      cnt        <= '0;
      idx        <= '0;
      domain_rst <= '1;
      ready      <= 1'b0;
    end else begin
      unique case (state)
        ASSERTED: begin
          cnt   <= '0;
          state <= STRETCH;
        end
        STRETCH: begin
          if (cnt == CW'(STRETCH_CYCLES - 1)) begin
            cnt           <= '0;
            domain_rst[0] <= 1'b0;
            idx           <= IW'(1);
            state         <= (N_DOMAINS == 1) ? RUN : RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == CW'(STAGGER_CYCLES - 1)) begin
            cnt             <= '0;
            domain_rst[idx] <= 1'b0;
            idx             <= idx + 1'b1;
            if (idx == IW'(N_DOMAINS - 1)) state <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: state <= ASSERTED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      por_mismatch <= 1'b0;
    end else if (mismatch) begin
      por_mismatch <= 1'b1;
    end
  end

`ifdef RESET_SEQ_MISMATCH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_cnt <= '0;
    end else if (mismatch && (mismatch_cnt != '1)) begin
      mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
`endif

endmodule
